decode_pipe_stage: RTL and testbench

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

---
 rtl/decode_pkg.sv | 62 ++++++
 rtl/decode_ctrl.sv | 96 +++++++++
 rtl/decode_pipe_stage.sv | 198 +++++++++++++++++++
 tb/tb_decode_pipe_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, control bundle, dest-select and state enums for the decode stage
package decode_pkg;

  localparam int SEL_W = 3;

  localparam logic [4:0] OP_ALU  = 5'h00;
  localparam logic [4:0] OP_ADDI = 5'h01;
  localparam logic [4:0] OP_ORI  = 5'h02;
  localparam logic [4:0] OP_LI   = 5'h03;
  localparam logic [4:0] OP_LD   = 5'h04;
  localparam logic [4:0] OP_ST   = 5'h05;
  localparam logic [4:0] OP_BEQZ = 5'h06;
  localparam logic [4:0] OP_BNEZ = 5'h07;
  localparam logic [4:0] OP_BLTZ = 5'h08;
  localparam logic [4:0] OP_BGEZ = 5'h09;
  localparam logic [4:0] OP_J    = 5'h0A;
  localparam logic [4:0] OP_JAL  = 5'h0B;
  localparam logic [4:0] OP_JR   = 5'h0C;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [1:0] {
    DST_RS = 2'd0,
    DST_RT = 2'd1,
    DST_RD = 2'd2,
    DST_R7 = 2'd3
  } dest_sel_e;

  typedef enum logic [1:0] {
    BR_EQZ = 2'd0,
    BR_NEZ = 2'd1,
    BR_LTZ = 2'd2,
    BR_GEZ = 2'd3
  } br_cond_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      jump_reg;
    logic      sign_imm;
    logic      imm_five;
    logic      use_disp;
    br_cond_e  br_cond;
    logic [1:0] alu_op;
    dest_sel_e dest_sel;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_e;

endpackage

// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - combinational opcode decoder producing the control bundle and operand usage
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [4:0] i_opcode,
  input  logic [1:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_uses_rs,
  output logic       o_uses_rt,
  output logic       o_illegal
);

  // Map each opcode to its control bundle; anything unlisted decodes as an illegal no-op
  always_comb begin
    o_ctrl    = '0;
    o_uses_rs = 1'b0;
    o_uses_rt = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_ALU: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.dest_sel  = DST_RD;
        o_ctrl.alu_op    = i_funct;
        o_uses_rs        = 1'b1;
        o_uses_rt        = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.dest_sel  = DST_RT;
        o_ctrl.sign_imm  = 1'b1;
        o_ctrl.imm_five  = 1'b1;
        o_ctrl.alu_op    = ALU_ADD;
        o_uses_rs        = 1'b1;
      end
      OP_ORI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.dest_sel  = DST_RT;
        o_ctrl.imm_five  = 1'b1;
        o_ctrl.alu_op    = ALU_OR;
        o_uses_rs        = 1'b1;
      end
      OP_LI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.dest_sel  = DST_RS;
        o_ctrl.sign_imm  = 1'b1;
      end
      OP_LD: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.dest_sel  = DST_RT;
        o_ctrl.sign_imm  = 1'b1;
        o_ctrl.imm_five  = 1'b1;
        o_uses_rs        = 1'b1;
      end
      OP_ST: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.sign_imm  = 1'b1;
        o_ctrl.imm_five  = 1'b1;
        o_uses_rs        = 1'b1;
        o_uses_rt        = 1'b1;
      end
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
        o_ctrl.branch   = 1'b1;
        o_ctrl.sign_imm = 1'b1;
        o_uses_rs       = 1'b1;
        case (i_opcode)
          OP_BEQZ: o_ctrl.br_cond = BR_EQZ;
          OP_BNEZ: o_ctrl.br_cond = BR_NEZ;
          OP_BLTZ: o_ctrl.br_cond = BR_LTZ;
          default: o_ctrl.br_cond = BR_GEZ;
        endcase
      end
      OP_J: begin
        o_ctrl.jump     = 1'b1;
        o_ctrl.use_disp = 1'b1;
        o_ctrl.sign_imm = 1'b1;
      end
      OP_JAL: begin
        o_ctrl.jump      = 1'b1;
        o_ctrl.use_disp  = 1'b1;
        o_ctrl.sign_imm  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.dest_sel  = DST_R7;
      end
      OP_JR: begin
        o_ctrl.jump     = 1'b1;
        o_ctrl.jump_reg = 1'b1;
        o_ctrl.sign_imm = 1'b1;
        o_ctrl.imm_five = 1'b1;
        o_uses_rs       = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// rtl/decode_pipe_stage.sv - decode stage with register file, load-use FSM and output register; option macro DECODE_RF_BYPASS_EN
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int INSTR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  pc_plus2,
  input  logic               wb_en,
  input  logic [SEL_W-1:0]   wb_sel,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_rs_data,
  output logic [DATA_W-1:0]  out_rt_data,
  output logic [DATA_W-1:0]  out_imm,
  output logic [SEL_W-1:0]   out_dest,
  output ctrl_t              out_ctrl,
  output logic               redirect,
  output logic [DATA_W-1:0]  redirect_pc,
  output logic               err
);

  logic [4:0]        w_opcode;
  logic [SEL_W-1:0]  w_rs, w_rt, w_rd;
  logic [1:0]        w_funct;
  logic [4:0]        w_imm5;
  logic [7:0]        w_imm8;
  logic [10:0]       w_disp;
  ctrl_t             w_ctrl;
  logic              w_uses_rs, w_uses_rt, w_illegal;
  logic              w_wb_ok, w_load_use, w_wb_stall, w_hazard, w_accept;
  logic [DATA_W-1:0] w_rs_data, w_rt_data, w_imm, w_target;
  logic [SEL_W-1:0]  w_dest;
  logic              w_cond, w_taken;
  state_e            r_state, w_state_nxt;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm, r_redirect_pc;
  logic [SEL_W-1:0]  r_dest;
  ctrl_t             r_ctrl;
  logic              r_redirect, r_err;

  assign w_opcode = instr[15:11];
  assign w_rs     = instr[10:8];
  assign w_rt     = instr[7:5];
  assign w_rd     = instr[4:2];
  assign w_funct  = instr[1:0];
  assign w_imm5   = instr[4:0];
  assign w_imm8   = instr[7:0];
  assign w_disp   = instr[10:0];

  decode_ctrl u_ctrl (
    .i_opcode  (w_opcode),
    .i_funct   (w_funct),
    .o_ctrl    (w_ctrl),
    .o_uses_rs (w_uses_rs),
    .o_uses_rt (w_uses_rt),
    .o_illegal (w_illegal)
  );

  // Writes to a select beyond the implemented file are dropped and flagged in err
  assign w_wb_ok = wb_en & (32'(wb_sel) < NUM_REGS);

  // Register file read ports; unimplemented selects read as zero
  always_comb begin
    w_rs_data = '0;
    w_rt_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rs == SEL_W'(i)) w_rs_data = r_regs[i];
      if (w_rt == SEL_W'(i)) w_rt_data = r_regs[i];
    end
`ifdef DECODE_RF_BYPASS_EN
    if (w_wb_ok && (wb_sel == w_rs)) w_rs_data = wb_data;
    if (w_wb_ok && (wb_sel == w_rt)) w_rt_data = wb_data;
`endif
  end

  // Immediate: jumps take disp11, otherwise imm5 or imm8 with optional sign extension
  always_comb begin
    if (w_ctrl.use_disp)
      w_imm = {{(DATA_W-11){w_disp[10]}}, w_disp};
    else if (w_ctrl.imm_five)
      w_imm = {{(DATA_W-5){w_ctrl.sign_imm & w_imm5[4]}}, w_imm5};
    else
      w_imm = {{(DATA_W-8){w_ctrl.sign_imm & w_imm8[7]}}, w_imm8};
  end

  // Destination register selection and branch resolution on the forwarded rs value
  always_comb begin
    case (w_ctrl.dest_sel)
      DST_RS:  w_dest = w_rs;
      DST_RT:  w_dest = w_rt;
      DST_RD:  w_dest = w_rd;
      default: w_dest = 3'd7;
    endcase
    case (w_ctrl.br_cond)
      BR_EQZ:  w_cond = (w_rs_data == '0);
      BR_NEZ:  w_cond = (w_rs_data != '0);
      BR_LTZ:  w_cond = w_rs_data[DATA_W-1];
      default: w_cond = ~w_rs_data[DATA_W-1];
    endcase
    w_taken  = w_ctrl.jump | (w_ctrl.branch & w_cond);
    w_target = (w_ctrl.jump_reg ? w_rs_data : pc_plus2) + w_imm;
  end

  assign w_load_use = out_valid & r_ctrl.mem_read & r_ctrl.reg_write &
                      ((w_uses_rs & (r_dest == w_rs)) | (w_uses_rt & (r_dest == w_rt)));

`ifdef DECODE_RF_BYPASS_EN
  assign w_wb_stall = 1'b0;
`else
  assign w_wb_stall = w_wb_ok & ((w_uses_rs & (wb_sel == w_rs)) | (w_uses_rt & (wb_sel == w_rt)));
`endif

  assign w_hazard  = w_load_use | w_wb_stall;
  assign out_valid = (r_state == ST_HOLD);
  assign in_ready  = rst & (~out_valid | out_ready) & ~w_hazard & ~flush;
  assign w_accept  = in_valid & in_ready;

  // Next state: flush empties, accept holds, a drain blocked by a hazard leaves one bubble
  always_comb begin
    w_state_nxt = r_state;
    if (flush)
      w_state_nxt = ST_EMPTY;
    else if (w_accept)
      w_state_nxt = ST_HOLD;
    else begin
      case (r_state)
        ST_HOLD:   if (out_ready) w_state_nxt = w_hazard ? ST_BUBBLE : ST_EMPTY;
        ST_BUBBLE: w_state_nxt = ST_EMPTY;
        default:   w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Register file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wb_sel == SEL_W'(i)) r_regs[i] <= wb_data;
    end
  end

  // Output pipeline register loads on accept; redirect is a single-cycle pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
      r_dest        <= '0;
      r_ctrl        <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= w_accept & w_taken;
      if (w_accept) begin
        r_rs_data <= w_rs_data;
        r_rt_data <= w_rt_data;
        r_imm     <= w_imm;
        r_dest    <= w_dest;
        r_ctrl    <= w_ctrl;
        if (w_taken) r_redirect_pc <= w_target;
      end
    end
  end

  // Sticky error: illegal opcode accepted or out-of-range writeback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= r_err | (w_accept & w_illegal) | (wb_en & ~w_wb_ok);
  end

  assign out_rs_data = r_rs_data;
  assign out_rt_data = r_rt_data;
  assign out_imm     = r_imm;
  assign out_dest    = r_dest;
  assign out_ctrl    = r_ctrl;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign err         = r_err;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb/tb_decode_pipe_stage.sv - self-checking bench for decode_pipe_stage
module tb_decode_pipe_stage;
  import decode_pkg::*;

`ifdef DECODE_RF_BYPASS_EN
  localparam int EXP_BYP_STALLS = 0;
`else
  localparam int EXP_BYP_STALLS = 1;
`endif
  localparam int LIMIT = 16;

  logic        clk, rst, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
  logic        redirect, err;
  logic [15:0] instr, pc_plus2, wb_data, out_rs_data, out_rt_data, out_imm, redirect_pc;
  logic [2:0]  wb_sel, out_dest;
  ctrl_t       out_ctrl;

  int total = 0;
  int bad   = 0;
  logic [15:0] model [8];

  decode_pipe_stage #(.DATA_W(16), .NUM_REGS(8), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc_plus2(pc_plus2), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data), .out_imm(out_imm), .out_dest(out_dest), .out_ctrl(out_ctrl),
    .redirect(redirect), .redirect_pc(redirect_pc), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [2:0] rd);
    return {op, rs, rt, rd, 2'b00};
  endfunction

  // Immediate format per opcode: 0 none, 1 zero imm5, 2 signed imm5, 3 signed imm8, 4 signed disp11
  function automatic int m_kind(input logic [4:0] op);
    case (op)
      OP_ORI:                              return 1;
      OP_ADDI, OP_LD, OP_ST, OP_JR:        return 2;
      OP_LI, OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: return 3;
      OP_J, OP_JAL:                        return 4;
      default:                             return 0;
    endcase
  endfunction

  function automatic logic [15:0] m_imm(input logic [15:0] ins);
    int v;
    v = 0;
    case (m_kind(ins[15:11]))
      1: v = int'(ins[4:0]);
      2: begin v = int'(ins[4:0]);  if (v > 15)   v = v - 32;   end
      3: begin v = int'(ins[7:0]);  if (v > 127)  v = v - 256;  end
      4: begin v = int'(ins[10:0]); if (v > 1023) v = v - 2048; end
      default: v = 0;
    endcase
    return 16'(v);
  endfunction

  function automatic int m_dest(input logic [15:0] ins);
    case (ins[15:11])
      OP_ALU:                return int'(ins[4:2]);
      OP_ADDI, OP_ORI, OP_LD: return int'(ins[7:5]);
      OP_LI:                 return int'(ins[10:8]);
      OP_JAL:                return 7;
      default:               return -1;
    endcase
  endfunction

  function automatic logic m_taken(input logic [15:0] ins, input logic [15:0] rsv);
    case (ins[15:11])
      OP_BEQZ:             return rsv == 16'd0;
      OP_BNEZ:             return rsv != 16'd0;
      OP_BLTZ:             return $signed(rsv) < 0;
      OP_BGEZ:             return $signed(rsv) >= 0;
      OP_J, OP_JAL, OP_JR: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] m_target(input logic [15:0] ins, input logic [15:0] pc,
                                           input logic [15:0] rsv);
    return ((ins[15:11] == OP_JR) ? rsv : pc) + m_imm(ins);
  endfunction

  task automatic send(input logic [15:0] ins, input logic [15:0] pc, output int stalls);
    in_valid = 1'b1; instr = ins; pc_plus2 = pc; stalls = 0;
    #1;
    while (!in_ready && stalls < LIMIT) begin
      @(posedge clk); #1; stalls++;
    end
    total++;
    assert (stalls < LIMIT) else begin
      bad++;
      $error("FAIL send_timeout stalls=%0d limit=%0d", stalls, LIMIT);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [2:0] sel, input logic [15:0] data);
    wb_en = 1'b1; wb_sel = sel; wb_data = data;
    @(posedge clk); #1;
    wb_en = 1'b0;
    model[sel] = data;
  endtask

  initial begin
    int st, d;
    logic [15:0] ins, pc, a_ins, b_ins;
    logic [4:0] op;

    rst = 1'b1; in_valid = 1'b0; instr = '0; pc_plus2 = '0; wb_en = 1'b0; wb_sel = '0;
    wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;

    // reset: in_ready must stay low even with a request pending
    #2 rst = 1'b0; in_valid = 1'b1; instr = enc_r(OP_ALU, 3'd1, 3'd2, 3'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_err", err, 0);
      chk("rst_redirect", redirect, 0);
    end
    chk("rst_out_rs", out_rs_data, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    rst = 1'b1; in_valid = 1'b0;

    // first accept right after release, then every register reads zero
    send(enc_r(OP_ALU, 3'd0, 3'd1, 3'd2), 16'h0, st);
    chk("first_accept_stalls", st, 0);
    chk("first_out_valid", out_valid, 1);
    for (int k = 0; k < 4; k++) begin
      send(enc_r(OP_ALU, 3'(2*k), 3'(2*k+1), 3'd0), 16'h0, st);
      chk("zero_rs", out_rs_data, 0);
      chk("zero_rt", out_rt_data, 0);
    end

    // write then read
    wb(3'd3, 16'h1234);
    send(enc_r(OP_ALU, 3'd3, 3'd0, 3'd5), 16'h0, st);
    chk("wr_rd_rs", out_rs_data, 16'h1234);
    chk("wr_rd_dest", out_dest, 5);
    chk("wr_rd_valid", out_valid, 1);

    // same-cycle writeback to a source register
    in_valid = 1'b1; instr = enc_r(OP_ALU, 3'd3, 3'd0, 3'd1);
    wb_en = 1'b1; wb_sel = 3'd3; wb_data = 16'hBEEF; model[3] = 16'hBEEF;
    st = 0; #1;
    while (!in_ready && st < LIMIT) begin
      @(posedge clk); #1; wb_en = 1'b0; st++; #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; wb_en = 1'b0;
    chk("byp_stalls", st, EXP_BYP_STALLS);
    chk("byp_rs", out_rs_data, 16'hBEEF);

    // load-use: exactly one bubble
    wb(3'd2, 16'h5A5A);
    send({OP_LD, 3'd0, 3'd2, 5'd0}, 16'h0, st);
    chk("ld_mem_read", out_ctrl.mem_read, 1);
    in_valid = 1'b1; instr = enc_r(OP_ALU, 3'd2, 3'd0, 3'd4);
    #1;
    chk("lu_stall_ready", in_ready, 0);
    @(posedge clk); #2;
    chk("lu_bubble_valid", out_valid, 0);
    chk("lu_bubble_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lu_issue_valid", out_valid, 1);
    chk("lu_issue_rs", out_rs_data, 16'h5A5A);
    chk("lu_issue_dest", out_dest, 4);

    // taken branch, then the same branch killed by flush
    wb(3'd1, 16'h0000);
    send({OP_BEQZ, 3'd1, 8'hFE}, 16'h0010, st);
    chk("br_redirect", redirect, 1);
    chk("br_target", redirect_pc, 16'h000E);
    @(posedge clk); #1;
    chk("br_pulse_end", redirect, 0);
    in_valid = 1'b1; instr = {OP_BEQZ, 3'd1, 8'hFE}; pc_plus2 = 16'h0010; flush = 1'b1;
    #1;
    chk("flush_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("flush_redirect", redirect, 0);
    chk("flush_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;

    // back-pressure for 4 cycles
    wb(3'd6, 16'h6666);
    a_ins = enc_r(OP_ALU, 3'd3, 3'd0, 3'd1);
    b_ins = enc_r(OP_ALU, 3'd6, 3'd0, 3'd2);
    out_ready = 1'b0;
    send(a_ins, 16'h0, st);
    in_valid = 1'b1; instr = b_ins;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_rs", out_rs_data, 16'hBEEF);
      chk("bp_dest", out_dest, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_b_rs", out_rs_data, 16'h6666);
    chk("bp_b_dest", out_dest, 2);
    @(posedge clk); #1;
    chk("bp_no_dup", out_valid, 0);

    // randomized legal instructions against the reference model
    for (int n = 0; n < 40; n++) begin
      wb(3'($urandom), 16'($urandom));
      op  = 5'($urandom_range(0, 12));
      ins = {op, 11'($urandom)};
      pc  = 16'($urandom);
      send(ins, pc, st);
      d = m_dest(ins);
      chk("rnd_rs", out_rs_data, model[ins[10:8]]);
      chk("rnd_rt", out_rt_data, model[ins[7:5]]);
      chk("rnd_regwr", out_ctrl.reg_write, d >= 0);
      if (d >= 0) chk("rnd_dest", out_dest, d);
      if (m_kind(op) != 0) chk("rnd_imm", out_imm, m_imm(ins));
      chk("rnd_redirect", redirect, m_taken(ins, model[ins[10:8]]));
      if (m_taken(ins, model[ins[10:8]])) chk("rnd_target", redirect_pc, m_target(ins, pc, model[ins[10:8]]));
    end

    // illegal opcode sets a sticky error
    chk("err_before", err, 0);
    send({5'h1F, 11'h000}, 16'h0, st);
    chk("err_set", err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
